// File: rtl/issue_scheduler_pkg.sv
// Shared types and sizes for the issue scheduler and its oldest-ready finder.
package issue_scheduler_pkg;

    localparam int unsigned BUF_SIZE  = 16;
    localparam int unsigned NUM_UNITS = 4;
    localparam int unsigned IDX_W     = $clog2(BUF_SIZE);
    localparam int unsigned UNIT_W    = 2;
    localparam int unsigned TAG_W     = 6;
    localparam int unsigned NESO_W    = 4;

    typedef logic [IDX_W-1:0] index_t;
    typedef logic [TAG_W-1:0] spectag_t;

    typedef enum logic [UNIT_W-1:0] {
        U_ALU    = 2'd0,
        U_BRANCH = 2'd1,
        U_LOAD   = 2'd2,
        U_STORE  = 2'd3
    } unit_t;

    typedef enum logic [1:0] {
        S_NOT_USED     = 2'd0,
        S_NOT_EXECUTED = 2'd1,
        S_EXECUTING    = 2'd2,
        S_DONE         = 2'd3
    } e_state_t;

    typedef struct packed {
        e_state_t          e_state;
        unit_t             Unit;
        logic              J_rdy;
        logic              K_rdy;
        logic              A_rdy;
        logic [NESO_W-1:0] number_of_early_store_ops;
        spectag_t          speculative_tag;
    } entry_t;

    typedef enum logic {
        F_IDLE  = 1'b0,
        F_OFFER = 1'b1
    } ufsm_t;

    // Loads and stores must wait until no older stores are outstanding.
    function automatic logic is_mem_unit(unit_t u);
        return (u == U_LOAD) || (u == U_STORE);
    endfunction

endpackage

// File: rtl/issue_scheduler_oldest_ready_finder.sv
// Priority-encodes the lowest-index ready, unexecuted entry for one unit class.
module oldest_ready_finder
    import issue_scheduler_pkg::*;
(
    input  entry_t [BUF_SIZE-1:0] entries_i,
    input  unit_t                 unit_i,
    input  logic                  excl_valid_i,
    input  index_t                excl_index_i,
    input  logic                  kill_valid_i,
    input  spectag_t              kill_mask_i,
    output logic                  found_o,
    output index_t                index_o
);

    logic [BUF_SIZE-1:0] cand;

    // Per-entry eligibility; the excluded index is the one being accepted this cycle.
    always_comb begin
        cand = '0;
        for (int i = 0; i < BUF_SIZE; i++) begin
            cand[i] = (entries_i[i].e_state == S_NOT_EXECUTED)
                   && (entries_i[i].Unit == unit_i)
                   && entries_i[i].J_rdy && entries_i[i].K_rdy && entries_i[i].A_rdy
                   && (!is_mem_unit(unit_i) || (entries_i[i].number_of_early_store_ops == '0))
                   && !(kill_valid_i && ((entries_i[i].speculative_tag & kill_mask_i) != '0))
                   && !(excl_valid_i && (excl_index_i == IDX_W'(i)));
        end
    end

    // Lowest index wins: scan downwards so the last hit is the oldest.
    always_comb begin
        found_o = |cand;
        index_o = '0;
        for (int i = BUF_SIZE - 1; i >= 0; i--) begin
            if (cand[i]) begin
                index_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Per-unit issue scheduler: oldest-ready selection, registered valid/ready offer,
// kill squash, freed-entry drop and saturating stall counters.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned STALL_W = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  entry_t [BUF_SIZE-1:0]               entries_all_i,
    input  logic   [NUM_UNITS-1:0]              fu_ready_i,
    input  logic                                kill_valid_i,
    input  spectag_t                            kill_mask_i,
    output logic   [NUM_UNITS-1:0]              issue_valid_o,
    output index_t [NUM_UNITS-1:0]              issue_index_o,
    output entry_t [NUM_UNITS-1:0]              issue_entry_o,
    output logic   [NUM_UNITS-1:0]              mark_issued_o,
    output logic   [NUM_UNITS-1:0][STALL_W-1:0] stall_cycles_o
);

    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    ufsm_t state_q [NUM_UNITS];
    ufsm_t state_d [NUM_UNITS];

    logic   [NUM_UNITS-1:0]              issue_valid_q, issue_valid_d;
    index_t [NUM_UNITS-1:0]              issue_index_q, issue_index_d;
    entry_t [NUM_UNITS-1:0]              issue_entry_q, issue_entry_d;
    logic   [NUM_UNITS-1:0][STALL_W-1:0] stall_q, stall_d;

    logic   [NUM_UNITS-1:0] in_offer;
    logic   [NUM_UNITS-1:0] found;
    logic   [NUM_UNITS-1:0] killed;
    logic   [NUM_UNITS-1:0] freed;
    logic   [NUM_UNITS-1:0] mark;
    index_t [NUM_UNITS-1:0] found_idx;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        oldest_ready_finder u_finder (
            .entries_i    (entries_all_i),
            .unit_i       (unit_t'(UNIT_W'(u))),
            .excl_valid_i (in_offer[u]),
            .excl_index_i (issue_index_q[u]),
            .kill_valid_i (kill_valid_i),
            .kill_mask_i  (kill_mask_i),
            .found_o      (found[u]),
            .index_o      (found_idx[u])
        );
    end

    // Offer status: squash, freed entry, and the handshake itself.
    always_comb begin
        in_offer = '0;
        killed   = '0;
        freed    = '0;
        mark     = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            in_offer[u] = (state_q[u] == F_OFFER);
            killed[u]   = kill_valid_i
                       && ((issue_entry_q[u].speculative_tag & kill_mask_i) != '0);
            freed[u]    = (entries_all_i[issue_index_q[u]].e_state == S_NOT_USED);
            mark[u]     = issue_valid_q[u] && fu_ready_i[u] && !killed[u] && !freed[u];
        end
    end

    assign mark_issued_o = mark;

    // FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                state_q[u] <= F_IDLE;
            end
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                state_q[u] <= state_d[u];
            end
        end
    end

    // Next state: no preemption; squash or free drops the offer, accept reloads if possible.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            state_d[u] = state_q[u];
            case (state_q[u])
                F_IDLE: begin
                    if (found[u]) begin
                        state_d[u] = F_OFFER;
                    end
                end
                F_OFFER: begin
                    if (killed[u] || freed[u]) begin
                        state_d[u] = F_IDLE;
                    end else if (mark[u]) begin
                        state_d[u] = found[u] ? F_OFFER : F_IDLE;
                    end
                end
                default: state_d[u] = F_IDLE;
            endcase
        end
    end

    // Output next values: snapshot on load, stall counting while the offer waits.
    always_comb begin
        issue_index_d = issue_index_q;
        issue_entry_d = issue_entry_q;
        issue_valid_d = '0;
        stall_d       = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (found[u] && ((state_q[u] == F_IDLE)
                             || ((state_q[u] == F_OFFER) && mark[u]))) begin
                issue_index_d[u] = found_idx[u];
                issue_entry_d[u] = entries_all_i[found_idx[u]];
            end
            issue_valid_d[u] = (state_d[u] == F_OFFER);
            if ((state_q[u] == F_OFFER) && !mark[u] && !killed[u] && !freed[u]) begin
                stall_d[u] = (stall_q[u] == STALL_MAX) ? STALL_MAX
                                                       : stall_q[u] + STALL_W'(1);
            end
        end
    end

    // Registered offer outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid_q <= '0;
            issue_index_q <= '0;
            issue_entry_q <= '0;
            stall_q       <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            issue_entry_q <= issue_entry_d;
            stall_q       <= stall_d;
        end
    end

    assign issue_valid_o  = issue_valid_q;
    assign issue_index_o  = issue_index_q;
    assign issue_entry_o  = issue_entry_q;
    assign stall_cycles_o = stall_q;

endmodule
